cnt_seq_ctrl: RTL and testbench

Command-driven sequencer for the team's free-running 8-bit counter datapath. It accepts commands over a valid/ready interface and drives the counter's enable and load inputs. It monitors the counter value to implement free-run, stop, preload and count-to-terminal (one-shot) modes. It sits between the top-level pin wrapper and the counter register.

---
 rtl/cnt_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_cnt_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_seq_ctrl.sv
// Command-driven sequencer for the 8-bit counter datapath: free-run, stop, preload and one-shot count-to-terminal.
// Optional enable prescaler is built when CNT_SEQ_PRESCALE_EN is defined.
module cnt_seq_ctrl #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_en,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             done,
  output logic             busy
);

  localparam logic [1:0] OP_STOP = 2'd0;
  localparam logic [1:0] OP_RUN  = 2'd1;
  localparam logic [1:0] OP_LOAD = 2'd2;
  localparam logic [1:0] OP_ARM  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_LOAD  = 3'd2,
    S_ARMED = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  if (PRESCALE_DIV < 2 || PRESCALE_DIV > 255) begin : g_bad_div
    $error("cnt_seq_ctrl: PRESCALE_DIV out of range 2..255");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [WIDTH-1:0] load_val_q, load_val_d;
  logic             ret_run_q, ret_run_d;
  logic             load_q, done_q;
  logic             accept;
  logic             tick;

  assign cmd_ready    = (state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_ARMED);
  assign accept       = cmd_valid && cmd_ready;
  assign busy         = (state_q != S_IDLE);
  assign cnt_load     = load_q;
  assign cnt_load_val = load_val_q;
  assign done         = done_q;

`ifdef CNT_SEQ_PRESCALE_EN
  localparam int unsigned PW = $clog2(PRESCALE_DIV);

  logic [PW-1:0] presc_q, presc_d;

  assign tick = (presc_q == PW'(PRESCALE_DIV - 1));

  // Prescaler only runs while the state is steady in RUN or ARMED
  always_comb begin
    presc_d = '0;
    if ((state_d == state_q) && ((state_q == S_RUN) || (state_q == S_ARMED))) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Next-state and combinational enable; an accepted command overrides the state's own progression
  always_comb begin
    state_d    = state_q;
    term_d     = term_q;
    load_val_d = load_val_q;
    ret_run_d  = ret_run_q;
    cnt_en     = 1'b0;

    case (state_q)
      S_IDLE: ;
      S_RUN:  cnt_en = tick;
      S_LOAD: state_d = ret_run_q ? S_RUN : S_IDLE;
      S_ARMED: begin
        cnt_en = tick && (cnt_value != term_q);
        if (cnt_value == term_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      case (cmd_op)
        OP_STOP: state_d = S_IDLE;
        OP_RUN:  state_d = S_RUN;
        OP_LOAD: begin
          state_d    = S_LOAD;
          load_val_d = cmd_data;
          ret_run_d  = (state_q == S_RUN);
        end
        OP_ARM: begin
          state_d = S_ARMED;
          term_d  = cmd_data;
        end
      endcase
    end
  end

  // State and registered outputs; load/done strobes mirror the LOAD/DONE states
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      term_q     <= '0;
      load_val_q <= '0;
      ret_run_q  <= 1'b0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      term_q     <= term_d;
      load_val_q <= load_val_d;
      ret_run_q  <= ret_run_d;
      load_q     <= (state_d == S_LOAD);
      done_q     <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Self-checking bench for cnt_seq_ctrl with a behavioural counter and an event scoreboard.
// Build with CNT_SEQ_PRESCALE_EN to exercise the prescaled enable.
module tb_cnt_seq_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIV   = 4;
`ifdef CNT_SEQ_PRESCALE_EN
  localparam int unsigned DIV_EFF = DIV;
`else
  localparam int unsigned DIV_EFF = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] cnt_value;
  logic             cnt_en;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_val;
  logic             done;
  logic             busy;

  logic [WIDTH-1:0] ctr;
  logic             preset_req;
  logic [WIDTH-1:0] preset_val;
  int               en_count   = 0;
  int               done_count = 0;
  int               n_tests    = 0;
  int               n_fail     = 0;

  typedef struct {
    logic             is_done;
    logic [WIDTH-1:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  cnt_seq_ctrl #(.WIDTH(WIDTH), .PRESCALE_DIV(DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cnt_value    (cnt_value),
    .cnt_en       (cnt_en),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .done         (done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Counter datapath the controller drives
  always @(posedge clk) begin
    if (preset_req)    ctr <= preset_val;
    else if (cnt_load) ctr <= cnt_load_val;
    else if (cnt_en)   ctr <= ctr + 8'd1;
  end
  assign cnt_value = ctr;

  always @(posedge clk) begin
    if (cnt_en && !cnt_load) en_count <= en_count + 1;
    if (done) done_count <= done_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every load or done strobe must match the next queued expectation
  always @(negedge clk) begin
    if (rst_n && (cnt_load || done)) begin
      if (cnt_load && done) check("load_done_overlap", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'd0, cnt_load, done}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        if (cnt_load) begin
          check("load_kind", 32'd0, {31'd0, mon_e.is_done});
          check("load_val", {24'd0, cnt_load_val}, {24'd0, mon_e.val});
        end else begin
          check("done_kind", 32'd1, {31'd0, mon_e.is_done});
          check("done_cnt", {24'd0, cnt_value}, {24'd0, mon_e.val});
        end
      end
    end
  end

  task automatic push_exp(input logic is_done, input logic [WIDTH-1:0] val);
    exp_t e;
    e.is_done = is_done;
    e.val     = val;
    exp_q.push_back(e);
  endtask

  // Present a command and hold it until the edge that accepts it; returns just after that edge
  task automatic send_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data);
    int waited;
    waited = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) check("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 300);
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic arm_case(input logic [WIDTH-1:0] start, input logic [WIDTH-1:0] term, input int incr);
    int base, db, cyc;
    push_exp(1'b0, start);
    send_cmd(2'd2, start);
    push_exp(1'b1, term);
    db = done_count;
    send_cmd(2'd3, term);
    base = en_count - ((en_count > 0) ? 0 : 0);
    base = en_count;
    wait_done(cyc);
    check("arm_cycles", cyc, 2 + incr * DIV_EFF);
    check("arm_incr", en_count - base, incr);
    check("arm_busy_in_done", {31'd0, busy}, 32'd1);
    check("arm_hold", {24'd0, ctr}, {24'd0, term});
    @(negedge clk);
    check("arm_busy_after", {31'd0, busy}, 32'd0);
    check("arm_done_once", done_count - db, 1);
  endtask

  initial begin
    int base, db;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 2'd0;
    cmd_data   = '0;
    preset_req = 1'b1;
    preset_val = 8'h37;
    @(posedge clk);
    #1 preset_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_cnt_en", {31'd0, cnt_en}, 32'd0);
      check("rst_cnt_load", {31'd0, cnt_load}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_load_val", {24'd0, cnt_load_val}, 32'd0);
      check("rst_ctr_hold", {24'd0, ctr}, 32'h37);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // LOAD from idle, then free run through the wrap
    push_exp(1'b0, 8'hF0);
    send_cmd(2'd2, 8'hF0);
    check("load_ready_low", {31'd0, cmd_ready}, 32'd0);
    check("load_busy", {31'd0, busy}, 32'd1);
    send_cmd(2'd1, '0);
    check("run_start_ctr", {24'd0, ctr}, 32'hF0);
    base = en_count;
    repeat (20) @(posedge clk);
    #1;
    check("run_wrap_ctr", {24'd0, ctr}, (32'hF0 + 20 / DIV_EFF) & 32'hFF);
    check("run_incr", en_count - base, 20 / DIV_EFF);

    // LOAD while running returns to RUN
    push_exp(1'b0, 8'h10);
    send_cmd(2'd2, 8'h10);
    check("rload_ready_low", {31'd0, cmd_ready}, 32'd0);
    check("rload_en_low", {31'd0, cnt_en}, 32'd0);
    @(posedge clk);
    #1;
    check("rload_ready_back", {31'd0, cmd_ready}, 32'd1);
    check("rload_busy", {31'd0, busy}, 32'd1);
    check("rload_en_back", {31'd0, cnt_en}, (DIV_EFF == 1) ? 32'd1 : 32'd0);
    check("rload_ctr", {24'd0, ctr}, 32'h10);
    send_cmd(2'd0, '0);
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_ctr", {24'd0, ctr}, (DIV_EFF == 1) ? 32'h11 : 32'h10);

    // One-shot counts, including wrap and already-at-terminal
    arm_case(8'h05, 8'h0A, 5);
    arm_case(8'hFE, 8'h03, 5);
    arm_case(8'h20, 8'h20, 0);

    // One-shot abandoned by STOP
    push_exp(1'b0, 8'h00);
    send_cmd(2'd2, 8'h00);
    db = done_count;
    send_cmd(2'd3, 8'h80);
    base = en_count;
    repeat (9) @(posedge clk);
    send_cmd(2'd0, '0);
    check("abort_ctr", {24'd0, ctr}, 10 / DIV_EFF);
    check("abort_incr", en_count - base, 10 / DIV_EFF);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    check("abort_no_done", done_count - db, 0);
    check("abort_hold", {24'd0, ctr}, 10 / DIV_EFF);

    // Enable rate over a fixed RUN window
    send_cmd(2'd1, '0);
    base = en_count;
    repeat (16) @(posedge clk);
    #1;
    check("rate_incr", en_count - base, 16 / DIV_EFF);
    send_cmd(2'd0, '0);

    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
